// File: rtl/lvds_nibble_deframer_pkg.sv
// lvds_link_pkg: types and constants shared by the 4-bit LVDS link blocks.
//   nibble_t          - one lane nibble
//   deframer_state_t  - receive framing states
//   SYNC0/SYNC1_DEFAULT - sync pair, also used by the TX framer
package lvds_link_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        HUNT,
        SYNC1_WAIT,
        PAYLOAD,
        CHECK
    } deframer_state_t;

    localparam nibble_t SYNC0_DEFAULT = 4'hA;
    localparam nibble_t SYNC1_DEFAULT = 4'h5;

endpackage

// File: rtl/lvds_nibble_deframer_if.sv
// lvds_nibble_deframer_if: valid/ready byte stream leaving the deframer.
//   data  - payload byte at the FIFO head
//   last  - head byte is the last payload byte of its frame
//   valid - a byte is available
//   ready - downstream takes the head when valid & ready
interface lvds_nibble_deframer_if;

    logic [7:0] data;
    logic       last;
    logic       valid;
    logic       ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);

endinterface

// File: rtl/lvds_nibble_deframer_fifo.sv
// lvds_sync_fifo: single-clock FIFO holding {last, byte} words.
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata - write request and word
//   pop         - read request (ignored while empty)
//   rdata       - word at the head, held until popped
//   full, empty - occupancy flags
//   ovf         - 1-cycle pulse: a push was dropped because the FIFO was full
module lvds_sync_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [8:0] wdata,
    input  logic       pop,
    output logic [8:0] rdata,
    output logic       full,
    output logic       empty,
    output logic       ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= push && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lvds_nibble_deframer.sv
// lvds_nibble_deframer: receive framing stage of the 4-bit LVDS link.
// Hunts for the sync pair, assembles PAYLOAD_BYTES bytes (low nibble first),
// checks the XOR checksum nibble and buffers bytes for the downstream echo logic.
//   clk, rst_n          - clock, asynchronous active-low reset
//   rx_en, rx_nibble    - lane nibble, consumed only when rx_en is high
//   out_if (master)     - byte stream {data, last, valid, ready}
//   frame_ok, frame_err - 1-cycle checksum result pulses
//   ovf                 - 1-cycle pulse: byte dropped on a full FIFO
//   frame_cnt, err_cnt  - saturating good/bad frame counters
//
// state      | meaning
// HUNT       | waiting for SYNC0
// SYNC1_WAIT | SYNC0 seen, waiting for SYNC1
// PAYLOAD    | collecting 2*PAYLOAD_BYTES payload nibbles
// CHECK      | next nibble is the XOR checksum
module lvds_nibble_deframer
    import lvds_link_pkg::*;
#(
    parameter int      PAYLOAD_BYTES = 4,
    parameter int      FIFO_DEPTH    = 8,
    parameter nibble_t SYNC0         = SYNC0_DEFAULT,
    parameter nibble_t SYNC1         = SYNC1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_en,
    input  nibble_t     rx_nibble,
    lvds_nibble_deframer_if.master out_if,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        ovf,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int               IDX_W    = $clog2(2 * PAYLOAD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * PAYLOAD_BYTES - 1);

    deframer_state_t  state;
    logic [IDX_W-1:0] idx;
    nibble_t          xor_acc;
    nibble_t          low_nib;
    logic             push_req;
    logic [8:0]       push_word;
    logic [8:0]       head_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            idx       <= '0;
            xor_acc   <= '0;
            low_nib   <= '0;
            push_req  <= 1'b0;
            push_word <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            push_req  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_en) begin
                case (state)
                    HUNT: begin
                        if (rx_nibble == SYNC0) begin
                            state <= SYNC1_WAIT;
                        end
                    end
                    SYNC1_WAIT: begin
                        if (rx_nibble == SYNC1) begin
                            state   <= PAYLOAD;
                            idx     <= '0;
                            xor_acc <= '0;
                        end else if (rx_nibble != SYNC0) begin
                            state <= HUNT;
                        end
                    end
                    PAYLOAD: begin
                        xor_acc <= xor_acc ^ rx_nibble;
                        if (!idx[0]) begin
                            low_nib <= rx_nibble;
                        end else begin
                            // Bytes go out before the checksum is known; the
                            // push is registered so the FIFO write lands one cycle later.
                            push_req  <= 1'b1;
                            push_word <= {(idx == LAST_IDX), rx_nibble, low_nib};
                        end
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                    CHECK: begin
                        if (rx_nibble == xor_acc) begin
                            frame_ok <= 1'b1;
                            if (frame_cnt != 16'hFFFF) begin
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign fifo_pop = out_if.valid && out_if.ready;

    lvds_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (push_word),
        .pop   (fifo_pop),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (ovf)
    );

    assign out_if.valid = !fifo_empty;
    assign out_if.last  = head_word[8];
    assign out_if.data  = head_word[7:0];

    fifo_flags_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && fifo_empty));

endmodule
